// File: rtl/uart_mmio_ctrl.sv
// MMIO front end for the shared UART: TX/RX byte FIFOs, status/data registers,
// and free-running cycle and retired-instruction counters.
module uart_mmio_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        inst_retired,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FullCnt = (AW + 1)'(FIFO_DEPTH);

  localparam logic [7:0] AddrStatus  = 8'h00;
  localparam logic [7:0] AddrRxData  = 8'h04;
  localparam logic [7:0] AddrTxData  = 8'h08;
  localparam logic [7:0] AddrCycle   = 8'h10;
  localparam logic [7:0] AddrInstret = 8'h14;
  localparam logic [7:0] AddrCtrl    = 8'h18;

  logic [7:0]  r_tx_mem [FIFO_DEPTH];
  logic [7:0]  r_rx_mem [FIFO_DEPTH];
  logic [AW:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic        r_tx_ovf;
  logic [31:0] r_cycle, r_instret;

  logic [AW:0] w_tx_cnt, w_rx_cnt;
  logic        w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic        w_wr_tx, w_wr_ctrl, w_rd;
  logic        w_tx_push, w_tx_pop, w_tx_ovf, w_rx_push, w_rx_pop;
  logic [31:0] w_rd_val;
  logic        w_unused_wdata;

  assign w_tx_cnt   = r_tx_wp - r_tx_rp;
  assign w_rx_cnt   = r_rx_wp - r_rx_rp;
  assign w_tx_full  = (w_tx_cnt == FullCnt);
  assign w_rx_full  = (w_rx_cnt == FullCnt);
  assign w_tx_empty = (r_tx_wp == r_tx_rp);
  assign w_rx_empty = (r_rx_wp == r_rx_rp);

  assign w_wr_tx   = wr_en && (addr == AddrTxData);
  assign w_wr_ctrl = wr_en && (addr == AddrCtrl);
  assign w_rd      = rd_en && !wr_en;

  // Pop is evaluated first, so a store to a full FIFO that is draining this cycle still lands.
  assign w_tx_pop  = !w_tx_empty && tx_ready;
  assign w_tx_push = w_wr_tx && (!w_tx_full || w_tx_pop);
  assign w_tx_ovf  = w_wr_tx && w_tx_full && !w_tx_pop;
  assign w_rx_push = rx_valid && !w_rx_full;
  assign w_rx_pop  = w_rd && (addr == AddrRxData) && !w_rx_empty;

  assign tx_valid = !w_tx_empty;
  assign tx_data  = r_tx_mem[r_tx_rp[AW-1:0]];
  assign rx_ready = !w_rx_full;

  assign w_unused_wdata = ^wdata[31:8];

  always_comb begin
    w_rd_val = 32'b0;
    case (addr)
      AddrStatus:  w_rd_val = {29'b0, r_tx_ovf, !w_rx_empty, !w_tx_full};
      AddrRxData:  w_rd_val = w_rx_empty ? 32'b0 : {24'b0, r_rx_mem[r_rx_rp[AW-1:0]]};
      AddrCycle:   w_rd_val = r_cycle;
      AddrInstret: w_rd_val = r_instret;
      default:     w_rd_val = 32'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= wdata[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wp   <= '0;
      r_tx_rp   <= '0;
      r_rx_wp   <= '0;
      r_rx_rp   <= '0;
      r_tx_ovf  <= 1'b0;
      r_cycle   <= 32'b0;
      r_instret <= 32'b0;
      rdata     <= 32'b0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;

      if (w_wr_ctrl)     r_tx_ovf <= 1'b0;
      else if (w_tx_ovf) r_tx_ovf <= 1'b1;

      if (w_wr_ctrl) begin
        r_cycle   <= 32'b0;
        r_instret <= 32'b0;
      end else begin
        r_cycle <= r_cycle + 32'd1;
        if (inst_retired) r_instret <= r_instret + 32'd1;
      end

      // A colliding load and store performs the store and returns zero.
      if (rd_en) rdata <= wr_en ? 32'b0 : w_rd_val;
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl: expected loads and TX bytes are queued at
// issue time and compared by a monitor when the DUT produces them.
module tb_uart_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic        wr_en, rd_en;
  logic [31:0] wdata, rdata;
  logic        inst_retired;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;

  uart_mmio_ctrl #(.FIFO_DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .wdata        (wdata),
    .rdata        (rdata),
    .inst_retired (inst_retired),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t rd_q[$];
  exp_t tx_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endfunction

  // Monitor: inputs change on negedges, so values seen at posedge are pre-edge.
  always @(posedge clk) begin : mon
    logic       s_rd, s_tx;
    logic [7:0] s_txd;
    exp_t       e;
    s_rd  = rd_en && !rst;
    s_tx  = tx_valid && tx_ready && !rst;
    s_txd = tx_data;
    #1;
    if (s_rd) begin
      if (rd_q.size() == 0) begin
        n_total++;
        $display("FAIL rd_unexpected: got load 0x%08h, expected no load", rdata);
      end else begin
        e = rd_q.pop_front();
        check(e.name, rdata, e.val);
      end
    end
    if (s_tx) begin
      if (tx_q.size() == 0) begin
        n_total++;
        $display("FAIL tx_unexpected: got byte 0x%02h, expected no byte", s_txd);
      end else begin
        e = tx_q.pop_front();
        check(e.name, {24'b0, s_txd}, e.val);
      end
    end
  end

  // All tasks start and end on a negedge.
  task automatic rd(input logic [7:0] a, input logic [31:0] v, input string n);
    exp_t x;
    x.name = n;
    x.val  = v;
    rd_q.push_back(x);
    addr  = a;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    addr  = 8'h00;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    addr  = 8'h00;
  endtask

  task automatic expect_tx(input logic [7:0] b);
    exp_t x;
    x.name = "tx_byte";
    x.val  = {24'b0, b};
    tx_q.push_back(x);
  endtask

  task automatic rx_put(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; addr = 8'h00; wr_en = 1'b0; rd_en = 1'b0; wdata = 32'b0;
    inst_retired = 1'b0; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    idle(3);
    rst = 1'b0;

    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_rdata", rdata, 32'd0);
    rd(8'h00, 32'h1, "status_reset");
    // CYCLE read is sampled on the 6th edge after release; five increments precede it.
    idle(4);
    rd(8'h10, 32'd5, "cycle_after_reset");

    // Fill TX with the transmitter stalled, then overflow once.
    for (int i = 0; i < 8; i++) begin
      wr(8'h08, 32'h41 + i);
      expect_tx(8'(8'h41 + i));
    end
    rd(8'h00, 32'h0, "status_tx_full");
    wr(8'h08, 32'h49);
    rd(8'h00, 32'h4, "status_tx_ovf");
    tx_ready = 1'b1;
    idle(12);
    check("tx_drained", 32'(tx_q.size()), 32'd0);
    check("tx_valid_idle", 32'(tx_valid), 32'd0);
    rd(8'h00, 32'h5, "status_after_drain");

    // RX bytes in order, then an empty read.
    rx_put(8'h78); rx_put(8'h79); rx_put(8'h7a); rx_put(8'h0d);
    rd(8'h00, 32'h7, "status_rx_nonempty");
    rd(8'h04, 32'h78, "rx_data0");
    rd(8'h04, 32'h79, "rx_data1");
    rd(8'h04, 32'h7a, "rx_data2");
    rd(8'h04, 32'h0d, "rx_data3");
    rd(8'h04, 32'h0, "rx_empty_read");
    rd(8'h00, 32'h5, "status_rx_empty");

    // RX back-pressure: 9th byte waits until a slot frees.
    for (int i = 0; i < 8; i++) rx_put(8'(8'h30 + i));
    check("rx_ready_full", 32'(rx_ready), 32'd0);
    rx_data  = 8'h38;
    rx_valid = 1'b1;
    idle(2);
    check("rx_ready_held", 32'(rx_ready), 32'd0);
    rd(8'h04, 32'h30, "rx_pop_full");
    check("rx_ready_reopen", 32'(rx_ready), 32'd1);
    idle(1);
    rx_valid = 1'b0;
    check("rx_ready_refull", 32'(rx_ready), 32'd0);
    for (int i = 1; i < 9; i++) rd(8'h04, 32'h30 + i, "rx_drain");
    rd(8'h00, 32'h5, "status_rx_drained");

    // Instret counting, and CTRL clear colliding with a retire pulse.
    inst_retired = 1'b1;
    idle(3);
    inst_retired = 1'b0;
    rd(8'h14, 32'd3, "instret_3");
    inst_retired = 1'b1;
    wr(8'h18, 32'hdead_beef);
    inst_retired = 1'b0;
    rd(8'h14, 32'd0, "instret_cleared");
    rd(8'h00, 32'h1, "status_ovf_cleared");
    rd(8'h10, 32'd2, "cycle_cleared");

    // Store into a full TX FIFO on the same edge the transmitter pops: accepted.
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr(8'h08, 32'h50 + i);
      expect_tx(8'(8'h50 + i));
    end
    tx_ready = 1'b1;
    wr(8'h08, 32'h58);
    expect_tx(8'h58);
    idle(12);
    check("tx_drained_pushpop", 32'(tx_q.size()), 32'd0);
    rd(8'h00, 32'h1, "status_no_ovf");

    // Reset with bytes queued in both FIFOs discards them.
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(8'h08, 32'h61 + i);
    rx_put(8'h11);
    rx_put(8'h12);
    check("pre_rst_tx_valid", 32'(tx_valid), 32'd1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("post_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("post_rst_rx_ready", 32'(rx_ready), 32'd1);
    check("post_rst_rdata", rdata, 32'd0);
    rd(8'h00, 32'h1, "status_after_rst");
    tx_ready = 1'b1;
    idle(4);
    rd(8'h04, 32'h0, "rx_empty_after_rst");

    idle(1);
    check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    check("tx_queue_empty", 32'(tx_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
